// File: rtl/life_pkg.sv
// rtl/life_pkg.sv - shared types, defaults and decode helpers for the life run scheduler
package life_pkg;

    localparam int GRID_W_DEF = 64;
    localparam int GRID_H_DEF = 48;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_RUN    = 3'd2,
        ST_STEP   = 3'd3,
        ST_CLEAR  = 3'd4,
        ST_EDIT   = 3'd5,
        ST_TOGGLE = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        OP_STEP   = 2'd0,
        OP_LOAD   = 2'd1,
        OP_CLEAR  = 2'd2,
        OP_TOGGLE = 2'd3
    } eng_op_t;

    // Encoded so that a larger value always means a higher priority command.
    typedef enum logic [2:0] {
        CMD_NONE   = 3'd0,
        CMD_MANUAL = 3'd1,
        CMD_START  = 3'd2,
        CMD_PAUSE  = 3'd3,
        CMD_CLEAR  = 3'd4
    } cmd_t;

    function automatic cmd_t cmd_max(input cmd_t a, input cmd_t b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic is_req_state(input state_t s);
        return (s == ST_LOAD) || (s == ST_STEP) || (s == ST_CLEAR) || (s == ST_TOGGLE);
    endfunction

    function automatic eng_op_t op_of(input state_t s);
        case (s)
            ST_LOAD:   return OP_LOAD;
            ST_CLEAR:  return OP_CLEAR;
            ST_TOGGLE: return OP_TOGGLE;
            default:   return OP_STEP;
        endcase
    endfunction

    // Where a resting state goes when a command arrives; also applied to a pending command after an ack.
    function automatic state_t cmd_next(input state_t s, input cmd_t c);
        if (c == CMD_CLEAR) return ST_CLEAR;
        case (s)
            ST_IDLE: begin
                if (c == CMD_START)  return ST_RUN;
                if (c == CMD_MANUAL) return ST_EDIT;
                return ST_IDLE;
            end
            ST_RUN: begin
                if (c == CMD_PAUSE) return ST_IDLE;
                return ST_RUN;
            end
            ST_EDIT: begin
                if (c == CMD_START)  return ST_RUN;
                if (c == CMD_MANUAL) return ST_IDLE;
                return ST_EDIT;
            end
            default: return s;
        endcase
    endfunction

endpackage

// File: rtl/life_tick_gen.sv
// rtl/life_tick_gen.sv - generation period counter; period is TICK_DIV >> speed_sel
module life_tick_gen #(
    parameter int TICK_DIV = 5_000_000
) (
    input  logic       clk_in,
    input  logic       reset_n,
    input  logic       en,
    input  logic [1:0] speed_sel,
    output logic       tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] last_q, last_d;
    logic [31:0]   period;

    // The terminal count is only reloaded when the counter returns to 0,
    // so a speed change never shortens or stretches a generation in flight.
    always_comb begin
        period = 32'(TICK_DIV) >> speed_sel;
        tick   = en && (cnt_q == last_q);
        cnt_d  = cnt_q;
        last_d = last_q;
        if (!en || tick) begin
            cnt_d  = '0;
            last_d = (period == 32'd0) ? '0 : CW'(period - 32'd1);
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q  <= '0;
            last_q <= CW'(TICK_DIV - 1);
        end else begin
            cnt_q  <= cnt_d;
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/life_run_scheduler.sv
// rtl/life_run_scheduler.sv - command FSM sequencing LOAD/STEP/CLEAR/TOGGLE requests to the life engine
module life_run_scheduler
    import life_pkg::*;
#(
    parameter int GRID_W   = GRID_W_DEF,
    parameter int GRID_H   = GRID_H_DEF,
    parameter int TICK_DIV = 5_000_000
) (
    input  logic                      clk_in,
    input  logic                      reset_n,
    input  logic                      cmd_start,
    input  logic                      cmd_pause,
    input  logic                      cmd_clear,
    input  logic                      cmd_manual,
    input  logic [3:0]                move,
    input  logic                      cell_toggle,
    input  logic [15:0]               file_id,
    input  logic [1:0]                speed_sel,
    output logic                      eng_req,
    output logic [1:0]                eng_op,
    output logic [15:0]               eng_file,
    input  logic                      eng_ack,
    output logic [$clog2(GRID_W)-1:0] cursor_x,
    output logic [$clog2(GRID_H)-1:0] cursor_y,
    output logic [2:0]                state,
    output logic [15:0]               gen_count
);

    localparam int XW = $clog2(GRID_W);
    localparam int YW = $clog2(GRID_H);

    state_t        state_q, state_d;
    cmd_t          pend_q, pend_d;
    eng_op_t       op_q, op_d;
    logic          req_q, req_d;
    logic [15:0]   file_q, file_d;
    logic [15:0]   last_id_q, last_id_d;
    logic [15:0]   gen_q, gen_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [3:0]    prev_q, prev_d;

    logic   [3:0] rise;
    cmd_t         edge_cmd;
    cmd_t         eff;
    state_t       nat;
    state_t       nxt;
    logic         ack_ok;
    logic         tick;

    life_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk_in    (clk_in),
        .reset_n   (reset_n),
        .en        (state_q == ST_RUN),
        .speed_sel (speed_sel),
        .tick      (tick)
    );

    always_comb begin
        prev_d    = {cmd_clear, cmd_pause, cmd_start, cmd_manual};
        rise      = prev_d & ~prev_q;
        edge_cmd  = rise[3] ? CMD_CLEAR :
                    rise[2] ? CMD_PAUSE :
                    rise[1] ? CMD_START :
                    rise[0] ? CMD_MANUAL : CMD_NONE;
        ack_ok    = req_q && eng_ack;
        state_d   = state_q;
        pend_d    = pend_q;
        gen_d     = gen_q;
        last_id_d = last_id_q;
        x_d       = x_q;
        y_d       = y_q;
        file_d    = file_q;
        op_d      = op_q;
        eff       = CMD_NONE;
        nat       = ST_IDLE;
        nxt       = ST_IDLE;

        case (state_q)
            ST_IDLE: begin
                nxt     = cmd_next(ST_IDLE, edge_cmd);
                state_d = (nxt == ST_IDLE && file_id != last_id_q) ? ST_LOAD : nxt;
            end
            ST_RUN: begin
                nxt     = cmd_next(ST_RUN, edge_cmd);
                state_d = (nxt == ST_RUN && tick) ? ST_STEP : nxt;
            end
            ST_EDIT: begin
                nxt = cmd_next(ST_EDIT, edge_cmd);
                if (nxt != ST_EDIT) begin
                    state_d = nxt;
                end else if (cell_toggle) begin
                    state_d = ST_TOGGLE;
                end else begin
                    // Non-one-hot move patterns fall through to the default and are ignored.
                    case (move)
                        4'b0001: x_d = (x_q == '0) ? XW'(GRID_W - 1) : x_q - XW'(1);
                        4'b0010: y_d = (y_q == '0) ? YW'(GRID_H - 1) : y_q - YW'(1);
                        4'b0100: y_d = (y_q == YW'(GRID_H - 1)) ? '0 : y_q + YW'(1);
                        4'b1000: x_d = (x_q == XW'(GRID_W - 1)) ? '0 : x_q + XW'(1);
                        default: ;
                    endcase
                end
            end
            default: begin
                // Request states: commands queue in one slot until the engine acknowledges.
                if (ack_ok) begin
                    eff    = cmd_max(pend_q, edge_cmd);
                    pend_d = CMD_NONE;
                    case (state_q)
                        ST_LOAD: begin
                            last_id_d = file_q;
                            gen_d     = '0;
                            nat       = ST_IDLE;
                        end
                        ST_STEP: begin
                            gen_d = gen_q + 16'd1;
                            nat   = ST_RUN;
                        end
                        ST_CLEAR: begin
                            gen_d = '0;
                            nat   = ST_IDLE;
                        end
                        default: nat = ST_EDIT;
                    endcase
                    state_d = cmd_next(nat, eff);
                end else begin
                    pend_d = cmd_max(pend_q, edge_cmd);
                end
            end
        endcase

        if (is_req_state(state_d) && (state_d != state_q || ack_ok)) begin
            op_d = op_of(state_d);
            if (state_d == ST_LOAD) file_d = file_id;
        end
        // A back-to-back request after an ack still sees one low cycle on eng_req.
        req_d = is_req_state(state_d) && !ack_ok;
    end

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            pend_q    <= CMD_NONE;
            op_q      <= OP_STEP;
            req_q     <= 1'b0;
            file_q    <= '0;
            last_id_q <= 16'hFFFF;
            gen_q     <= '0;
            x_q       <= '0;
            y_q       <= '0;
            prev_q    <= '0;
        end else begin
            state_q   <= state_d;
            pend_q    <= pend_d;
            op_q      <= op_d;
            req_q     <= req_d;
            file_q    <= file_d;
            last_id_q <= last_id_d;
            gen_q     <= gen_d;
            x_q       <= x_d;
            y_q       <= y_d;
            prev_q    <= prev_d;
        end
    end

    assign eng_req   = req_q;
    assign eng_op    = op_q;
    assign eng_file  = file_q;
    assign cursor_x  = x_q;
    assign cursor_y  = y_q;
    assign state     = state_q;
    assign gen_count = gen_q;

endmodule

// File: tb/tb_life_run_scheduler.sv
// tb/tb_life_run_scheduler.sv - directed scoreboard bench for life_run_scheduler
module tb_life_run_scheduler;

    logic        clk_in = 1'b0;
    logic        reset_n;
    logic        cmd_start, cmd_pause, cmd_clear, cmd_manual;
    logic [3:0]  move;
    logic        cell_toggle;
    logic [15:0] file_id;
    logic [1:0]  speed_sel;
    logic        eng_req;
    logic [1:0]  eng_op;
    logic [15:0] eng_file;
    logic        eng_ack;
    logic [5:0]  cursor_x;
    logic [5:0]  cursor_y;
    logic [2:0]  state;
    logic [15:0] gen_count;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [1:0]  op;
        logic [15:0] file;
        logic [5:0]  x;
        logic [5:0]  y;
    } exp_t;

    exp_t sb_q[$];

    always #5 clk_in = ~clk_in;

    life_run_scheduler #(.GRID_W(64), .GRID_H(48), .TICK_DIV(8)) dut (
        .clk_in      (clk_in),
        .reset_n     (reset_n),
        .cmd_start   (cmd_start),
        .cmd_pause   (cmd_pause),
        .cmd_clear   (cmd_clear),
        .cmd_manual  (cmd_manual),
        .move        (move),
        .cell_toggle (cell_toggle),
        .file_id     (file_id),
        .speed_sel   (speed_sel),
        .eng_req     (eng_req),
        .eng_op      (eng_op),
        .eng_file    (eng_file),
        .eng_ack     (eng_ack),
        .cursor_x    (cursor_x),
        .cursor_y    (cursor_y),
        .state       (state),
        .gen_count   (gen_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [1:0] op, input logic [15:0] file, input logic [5:0] x, input logic [5:0] y);
        exp_t e;
        e.op = op; e.file = file; e.x = x; e.y = y;
        sb_q.push_back(e);
    endtask

    // Waits for a request, scores it against the queue head, optionally pauses mid-request, then acks.
    task automatic serve(input string tag, input bit pause_mid, output int gap);
        exp_t e;
        int   k;
        k = 0;
        while (eng_req !== 1'b1 && k < 100) begin
            @(negedge clk_in);
            k++;
        end
        gap = k;
        check({tag, "_req"}, 32'(eng_req), 32'd1);
        check({tag, "_sb"}, 32'(sb_q.size() != 0), 32'd1);
        if (eng_req === 1'b1 && sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check({tag, "_op"},   32'(eng_op),   32'(e.op));
            check({tag, "_file"}, 32'(eng_file), 32'(e.file));
            check({tag, "_x"},    32'(cursor_x), 32'(e.x));
            check({tag, "_y"},    32'(cursor_y), 32'(e.y));
            @(negedge clk_in);
            if (pause_mid) cmd_pause = 1'b1;
            check({tag, "_hold_req"}, 32'(eng_req), 32'd1);
            check({tag, "_hold_op"},  32'(eng_op),  32'(e.op));
            @(negedge clk_in);
            cmd_pause = 1'b0;
            eng_ack   = 1'b1;
            @(negedge clk_in);
            eng_ack = 1'b0;
            check({tag, "_drop"}, 32'(eng_req), 32'd0);
        end
    endtask

    task automatic pulse_cycle;
        @(negedge clk_in);
    endtask

    initial begin
        int gap;
        int seen;
        reset_n     = 1'b0;
        cmd_start   = 1'b0;
        cmd_pause   = 1'b0;
        cmd_clear   = 1'b0;
        cmd_manual  = 1'b0;
        move        = 4'd0;
        cell_toggle = 1'b0;
        file_id     = 16'd3;
        speed_sel   = 2'd1;
        eng_ack     = 1'b0;

        repeat (2) @(negedge clk_in);
        check("rst_state", 32'(state),     32'd0);
        check("rst_req",   32'(eng_req),   32'd0);
        check("rst_op",    32'(eng_op),    32'd0);
        check("rst_file",  32'(eng_file),  32'd0);
        check("rst_gen",   32'(gen_count), 32'd0);
        check("rst_x",     32'(cursor_x),  32'd0);
        check("rst_y",     32'(cursor_y),  32'd0);

        // Reset release forces a load of the requested file.
        push(2'd1, 16'd3, 6'd0, 6'd0);
        reset_n = 1'b1;
        serve("load3", 1'b0, gap);
        check("load3_state", 32'(state),     32'd0);
        check("load3_gen",   32'(gen_count), 32'd0);

        // Run with period 8>>1 = 4 cycles between STEP requests.
        repeat (4) push(2'd0, 16'd3, 6'd0, 6'd0);
        cmd_start = 1'b1;
        @(negedge clk_in);
        cmd_start = 1'b0;
        check("run_state", 32'(state), 32'd2);
        serve("step1", 1'b0, gap);
        serve("step2", 1'b0, gap);
        check("step2_gap", 32'(gap), 32'd4);
        serve("step3", 1'b0, gap);
        check("step3_gap", 32'(gap), 32'd4);
        check("step3_gen", 32'(gen_count), 32'd3);

        // Pause while a STEP waits for its ack.
        serve("step4", 1'b1, gap);
        check("step4_gap",   32'(gap),       32'd4);
        check("pause_state", 32'(state),     32'd0);
        check("pause_gen",   32'(gen_count), 32'd4);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_in);
            if (eng_req === 1'b1) seen++;
        end
        check("pause_quiet", 32'(seen), 32'd0);

        // A stray ack with nothing outstanding changes nothing.
        eng_ack = 1'b1;
        @(negedge clk_in);
        eng_ack = 1'b0;
        @(negedge clk_in);
        check("stray_state", 32'(state),     32'd0);
        check("stray_gen",   32'(gen_count), 32'd4);
        check("stray_req",   32'(eng_req),   32'd0);

        // Edit mode cursor wrapping.
        cmd_manual = 1'b1;
        @(negedge clk_in);
        cmd_manual = 1'b0;
        check("edit_state", 32'(state), 32'd5);
        move = 4'b0001;
        @(negedge clk_in);
        move = 4'd0;
        check("edit_a_x", 32'(cursor_x), 32'd63);
        move = 4'b0010;
        @(negedge clk_in);
        move = 4'd0;
        check("edit_w_y", 32'(cursor_y), 32'd47);
        move = 4'b0011;
        @(negedge clk_in);
        move = 4'd0;
        check("edit_bad_x", 32'(cursor_x), 32'd63);
        check("edit_bad_y", 32'(cursor_y), 32'd47);

        push(2'd3, 16'd3, 6'd63, 6'd47);
        cell_toggle = 1'b1;
        @(negedge clk_in);
        cell_toggle = 1'b0;
        serve("toggle", 1'b0, gap);
        check("toggle_state", 32'(state), 32'd5);

        move = 4'b1000;
        @(negedge clk_in);
        move = 4'd0;
        check("edit_d_x", 32'(cursor_x), 32'd0);
        move = 4'b0100;
        @(negedge clk_in);
        move = 4'd0;
        check("edit_s_y", 32'(cursor_y), 32'd0);

        // Start from edit, then clear and start together inside RUN.
        cmd_start = 1'b1;
        @(negedge clk_in);
        cmd_start = 1'b0;
        check("edit_run_state", 32'(state), 32'd2);
        push(2'd2, 16'd3, 6'd0, 6'd0);
        cmd_clear = 1'b1;
        cmd_start = 1'b1;
        @(negedge clk_in);
        cmd_clear = 1'b0;
        cmd_start = 1'b0;
        check("clr_state", 32'(state), 32'd4);
        serve("clear", 1'b0, gap);
        check("clear_state", 32'(state),     32'd0);
        check("clear_gen",   32'(gen_count), 32'd0);

        // Reset in the middle of a CLEAR request.
        cmd_clear = 1'b1;
        @(negedge clk_in);
        cmd_clear = 1'b0;
        check("mid_req", 32'(eng_req), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("mid_rst_req",   32'(eng_req), 32'd0);
        check("mid_rst_state", 32'(state),   32'd0);
        file_id = 16'd7;
        @(negedge clk_in);
        push(2'd1, 16'd7, 6'd0, 6'd0);
        reset_n = 1'b1;
        serve("load7", 1'b0, gap);
        check("load7_state", 32'(state),     32'd0);
        check("load7_gen",   32'(gen_count), 32'd0);
        check("sb_empty",    32'(sb_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
